rca_pipe_addsub: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor: the next generation of the team's registered 64-bit RCA. The WIDTH-bit operation is split into STAGES equal ripple-carry segments, with one register boundary per segment. This gives one result per clock at high frequency. Adds subtract mode, carry-in, signed overflow, valid tagging and a global stall. It sits in the datapath wherever the registered RCA64 was used, and accepts a new operation every cycle.

---
 rtl/rca_pipe_addsub_if.sv | 40 ++++
 rtl/rca_pipe_addsub.sv | 121 ++++++++++++
 tb/tb_rca_pipe_addsub.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rca_pipe_addsub_if.sv
// Bus bundle for rca_pipe_addsub: operands, mode and stall going in,
// registered result coming out.
//
// Ports (signals):
//   in_valid  operands present this cycle
//   op1, op2  operands A and B (WIDTH bits)
//   cin       carry-in for add, borrow-in for subtract
//   sub       0 = add, 1 = subtract
//   stall     freezes the whole pipeline; inputs are ignored while high
//   out_valid result registers hold a new result this cycle
//   sum       result (WIDTH bits)
//   crout     raw carry out of the MSB (1 = no borrow when subtracting)
//   ovf       two's-complement overflow
//
// Modports: master drives the operation side (the source), slave is the
// adder itself.
interface rca_pipe_addsub_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             cin;
    logic             sub;
    logic             stall;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             crout;
    logic             ovf;

    modport master (
        output in_valid, op1, op2, cin, sub, stall,
        input  out_valid, sum, crout, ovf
    );

    modport slave (
        input  in_valid, op1, op2, cin, sub, stall,
        output out_valid, sum, crout, ovf
    );
endinterface

// File: rtl/rca_pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor.
//
// The WIDTH-bit operation is cut into STAGES equal segments of
// SEG = WIDTH/STAGES bits. Stage k ripples segment k using the carry
// registered by stage k-1, so the longest path is one SEG-bit ripple.
// Upper operand segments travel with the operation until their stage, and
// finished lower sum segments travel forward so the whole result lines up
// at the last stage.
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-low; clears valid bits and outputs at once
//   bus    rca_pipe_addsub_if.slave (operands/mode/stall in, result out)
//
// Parameters:
//   WIDTH   operand width, must be a multiple of STAGES
//   STAGES  pipeline depth and segment count, 1 <= STAGES <= WIDTH
//
// Handshake: an operation is accepted at a rising edge where
// in_valid = 1 and stall = 0. There is no ready; the source must hold or
// re-present an operation offered during stall, because stall = 1 freezes
// every register and ignores all inputs. out_valid pulses for one unstalled
// cycle per result (it is held through a stall), and sum/crout/ovf keep the
// last valid result while out_valid = 0. Latency is STAGES-1 edges after the
// accepting edge.
module rca_pipe_addsub #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input logic              clock,
    input logic              reset,
    rca_pipe_addsub_if.slave bus
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Stage boundary registers, element k is written by stage k.
    logic             v_r [STAGES];  // valid tag
    logic             c_r [STAGES];  // carry out of segment k
    logic [WIDTH-1:0] s_r [STAGES];  // sum segments 0..k are final
    logic [WIDTH-1:0] a_r [STAGES];  // operand A, segments above k still pending
    logic [WIDTH-1:0] b_r [STAGES];  // operand B' (already inverted for sub)
    logic             ovf_r;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;

        logic             v_i;
        logic             c_i;
        logic [WIDTH-1:0] a_i;
        logic [WIDTH-1:0] b_i;
        logic [WIDTH-1:0] s_i;
        logic [WIDTH-1:0] s_nxt;
        logic [SEG:0]     seg_res;

        if (k == 0) begin : g_head
            // Subtract is A + ~B + ~borrow; mode and carry are folded into
            // B' and c0 here so later stages only ever add.
            assign v_i = bus.in_valid;
            assign a_i = bus.op1;
            assign b_i = bus.sub ? ~bus.op2 : bus.op2;
            assign c_i = bus.cin ^ bus.sub;
            assign s_i = '0;
        end else begin : g_body
            assign v_i = v_r[k-1];
            assign a_i = a_r[k-1];
            assign b_i = b_r[k-1];
            assign c_i = c_r[k-1];
            assign s_i = s_r[k-1];
        end

        assign seg_res = {1'b0, a_i[LO +: SEG]} + {1'b0, b_i[LO +: SEG]}
                       + {{SEG{1'b0}}, c_i};

        always_comb begin
            s_nxt            = s_i;
            s_nxt[LO +: SEG] = seg_res[SEG-1:0];
        end

        // Data loads only behind a valid tag, so bubbles never disturb the
        // held result; the valid tag itself advances every unstalled cycle.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                v_r[k] <= 1'b0;
                c_r[k] <= 1'b0;
                s_r[k] <= '0;
                a_r[k] <= '0;
                b_r[k] <= '0;
            end else if (!bus.stall) begin
                v_r[k] <= v_i;
                if (v_i) begin
                    c_r[k] <= seg_res[SEG];
                    s_r[k] <= s_nxt;
                    a_r[k] <= a_i;
                    b_r[k] <= b_i;
                end
            end
        end

        if (k == LAST) begin : g_tail
            logic ovf_nxt;

            // Overflow when both addends share a sign that the sum lacks.
            assign ovf_nxt = (a_i[WIDTH-1] == b_i[WIDTH-1])
                          && (s_nxt[WIDTH-1] != a_i[WIDTH-1]);

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    ovf_r <= 1'b0;
                end else if (!bus.stall && v_i) begin
                    ovf_r <= ovf_nxt;
                end
            end
        end
    end

    assign bus.out_valid = v_r[LAST];
    assign bus.sum       = s_r[LAST];
    assign bus.crout     = c_r[LAST];
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_rca_pipe_addsub.sv
// Self-checking bench for rca_pipe_addsub. Three instances cover
// WIDTH/STAGES = 64/4, 32/1 and 48/8. Directed vectors carry hand-computed
// results; the back-to-back stream is checked against a plain full-width
// reference through per-instance expected queues.
module tb_rca_pipe_addsub;
    localparam int S64 = 4;
    localparam int S32 = 1;
    localparam int S48 = 8;

    logic clock;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;

    logic [65:0] exp_q64[$];
    logic [65:0] exp_q32[$];
    logic [65:0] exp_q48[$];

    rca_pipe_addsub_if #(.WIDTH(64)) if64 ();
    rca_pipe_addsub_if #(.WIDTH(32)) if32 ();
    rca_pipe_addsub_if #(.WIDTH(48)) if48 ();

    rca_pipe_addsub #(.WIDTH(64), .STAGES(S64)) u_dut64 (
        .clock (clock),
        .reset (reset),
        .bus   (if64)
    );
    rca_pipe_addsub #(.WIDTH(32), .STAGES(S32)) u_dut32 (
        .clock (clock),
        .reset (reset),
        .bus   (if32)
    );
    rca_pipe_addsub #(.WIDTH(48), .STAGES(S48)) u_dut48 (
        .clock (clock),
        .reset (reset),
        .bus   (if48)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(string tag, logic [66:0] got, logic [66:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int lat_of(int d);
        case (d)
            0:       return S64 - 1;
            1:       return S32 - 1;
            default: return S48 - 1;
        endcase
    endfunction

    function automatic int width_of(int d);
        case (d)
            0:       return 64;
            1:       return 32;
            default: return 48;
        endcase
    endfunction

    // {out_valid, ovf, crout, sum zero-extended to 64}
    function automatic logic [66:0] sample(int d);
        case (d)
            0:       return {if64.out_valid, if64.ovf, if64.crout, if64.sum};
            1:       return {if32.out_valid, if32.ovf, if32.crout, 32'b0, if32.sum};
            default: return {if48.out_valid, if48.ovf, if48.crout, 16'b0, if48.sum};
        endcase
    endfunction

    // Full-width reference: {ovf, crout, sum}
    function automatic logic [65:0] ref_op(int w, logic [63:0] a, logic [63:0] b,
                                           logic ci, logic s);
        logic [64:0] mask;
        logic [64:0] full;
        logic [63:0] am;
        logic [63:0] bm;
        logic        o;
        mask = (65'd1 << w) - 65'd1;
        am   = a & mask[63:0];
        bm   = (s ? ~b : b) & mask[63:0];
        full = {1'b0, am} + {1'b0, bm} + {64'b0, ci ^ s};
        o    = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
        return {o, full[w], full[63:0] & mask[63:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(int d, logic v, logic [63:0] a, logic [63:0] b,
                         logic ci, logic s);
        case (d)
            0: begin
                if64.in_valid = v; if64.op1 = a; if64.op2 = b;
                if64.cin = ci; if64.sub = s;
            end
            1: begin
                if32.in_valid = v; if32.op1 = a[31:0]; if32.op2 = b[31:0];
                if32.cin = ci; if32.sub = s;
            end
            default: begin
                if48.in_valid = v; if48.op1 = a[47:0]; if48.op2 = b[47:0];
                if48.cin = ci; if48.sub = s;
            end
        endcase
    endtask

    // One operation through instance d, then idle garbage behind it.
    task automatic run_dir(string tag, int d, logic [63:0] a, logic [63:0] b,
                           logic ci, logic s, logic [63:0] es, logic ec, logic eo);
        logic [66:0] got;
        drive(d, 1'b1, a, b, ci, s);
        step();
        drive(d, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, 64'hFFFF_0000_FFFF_0000, ~ci, ~s);
        for (int i = 0; i < lat_of(d); i++) begin
            got = sample(d);
            check($sformatf("%s_wait%0d", tag, i), {66'b0, got[66]}, 67'd0);
            step();
        end
        got = sample(d);
        check(tag, got, {1'b1, eo, ec, es});
        step();
        got = sample(d);
        check({tag, "_hold"}, got, {1'b0, eo, ec, es});
    endtask

    // ---------------- scoreboard ----------------
    task automatic push_exp(int d, logic [65:0] e);
        case (d)
            0:       exp_q64.push_back(e);
            1:       exp_q32.push_back(e);
            default: exp_q48.push_back(e);
        endcase
    endtask

    function automatic int exp_size(int d);
        case (d)
            0:       return exp_q64.size();
            1:       return exp_q32.size();
            default: return exp_q48.size();
        endcase
    endfunction

    task automatic pop_check(int d, int c, logic [66:0] got);
        logic [65:0] e;
        if (exp_size(d) == 0) begin
            check($sformatf("stream_d%0d_extra_c%0d", d, c), {66'b0, got[66]}, 67'd0);
        end else begin
            case (d)
                0:       e = exp_q64.pop_front();
                1:       e = exp_q32.pop_front();
                default: e = exp_q48.pop_front();
            endcase
            check($sformatf("stream_d%0d_c%0d", d, c), got, {1'b1, e});
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [66:0] got;
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rs;
        logic        rc;
        int          cnt[3];
        int          first_c[3];
        int          last_c[3];

        reset = 1'b0;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        if64.stall = 1'b0;
        if32.stall = 1'b0;
        if48.stall = 1'b0;

        step();
        for (int d = 0; d < 3; d++) begin
            got = sample(d);
            check($sformatf("reset_d%0d", d), got, 67'd0);
        end
        reset = 1'b1;

        // Directed, 64/4
        run_dir("add_basic", 0, 64'h1234_FFFF_DFFF_EEEE, 64'hDDDD_DDDD_DDDD_DDDD,
                1'b0, 1'b0, 64'hF012_DDDD_BDDD_CCCB, 1'b0, 1'b0);
        run_dir("add_carry_all", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
                1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        run_dir("add_ovf_pos", 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_dir("add_ovf_neg", 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
        run_dir("add_seg_edge", 0, 64'h0000_0000_0000_FFFF, 64'd1,
                1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        run_dir("sub_borrow", 0, 64'd5, 64'd7,
                1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_dir("sub_ovf", 0, 64'h8000_0000_0000_0000, 64'd1,
                1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        run_dir("sub_bin", 0, 64'd10, 64'd3,
                1'b1, 1'b1, 64'd6, 1'b1, 1'b0);

        // Directed, 32/1 (result registered at the accepting edge)
        run_dir("w32_ovf", 1, 64'h7FFF_FFFF, 64'd1,
                1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1);
        run_dir("w32_sub", 1, 64'd5, 64'd7,
                1'b0, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0);
        run_dir("w32_carry", 1, 64'hFFFF_FFFF, 64'd1,
                1'b0, 1'b0, 64'd0, 1'b1, 1'b0);

        // Directed, 48/8
        run_dir("w48_carry_all", 2, 64'hFFFF_FFFF_FFFF, 64'd0,
                1'b1, 1'b0, 64'd0, 1'b1, 1'b0);
        run_dir("w48_sub_ovf", 2, 64'h8000_0000_0000, 64'd1,
                1'b0, 1'b1, 64'h7FFF_FFFF_FFFF, 1'b1, 1'b1);

        // Back-to-back stream on all three, sub/cin toggling every cycle
        for (int d = 0; d < 3; d++) begin
            cnt[d] = 0; first_c[d] = -1; last_c[d] = -1;
        end
        for (int c = 0; c < 20; c++) begin
            for (int d = 0; d < 3; d++) begin
                if (c < 8) begin
                    ra = {$urandom(), $urandom()};
                    rb = {$urandom(), $urandom()};
                    rs = c[0];
                    rc = ~c[0];
                    push_exp(d, ref_op(width_of(d), ra, rb, rc, rs));
                    drive(d, 1'b1, ra, rb, rc, rs);
                end else begin
                    drive(d, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
                end
            end
            step();
            for (int d = 0; d < 3; d++) begin
                got = sample(d);
                if (got[66]) begin
                    cnt[d]++;
                    if (first_c[d] < 0) first_c[d] = c;
                    last_c[d] = c;
                    pop_check(d, c, got);
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("stream_d%0d_count", d), 67'(cnt[d]), 67'd8);
            check($sformatf("stream_d%0d_first", d), 67'(first_c[d]), 67'(lat_of(d)));
            check($sformatf("stream_d%0d_gapless", d), 67'(last_c[d] - first_c[d]), 67'd7);
            check($sformatf("stream_d%0d_left", d), 67'(exp_size(d)), 67'd0);
        end

        // Stall with three operations in flight on 64/4
        drive(0, 1'b1, 64'd1, 64'd2, 1'b0, 1'b0);  step();
        drive(0, 1'b1, 64'd10, 64'd3, 1'b0, 1'b1); step();
        drive(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        step();
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);  step();
        got = sample(0);
        check("stall_pre", got, {1'b1, 1'b0, 1'b0, 64'd3});
        if64.stall = 1'b1;
        drive(0, 1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 64'hBEEF_BEEF_BEEF_BEEF, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            got = sample(0);
            check($sformatf("stall_hold%0d", i), got, {1'b1, 1'b0, 1'b0, 64'd3});
        end
        if64.stall = 1'b0;
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        step();
        got = sample(0);
        check("stall_res1", got, {1'b1, 1'b0, 1'b1, 64'd7});
        step();
        got = sample(0);
        check("stall_res2", got, {1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        for (int i = 0; i < 3; i++) begin
            step();
            got = sample(0);
            check($sformatf("stall_after%0d", i), got, {1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        end

        // Reset mid-stream: one result showing, three behind it
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 64'(i + 1), 64'h100, 1'b0, 1'b0);
            step();
        end
        drive(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
        got = sample(0);
        check("rst_pre", got, {1'b1, 1'b0, 1'b0, 64'h101});
        reset = 1'b0;
        #1;
        got = sample(0);
        check("rst_async", got, 67'd0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got = sample(0);
            check($sformatf("rst_nostale%0d", i), got, 67'd0);
            step();
        end
        run_dir("post_rst", 0, 64'h0000_0000_0000_FFFF, 64'd1,
                1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
